// File: rtl/layer_pkg.sv
// ============================================================================
// Module      : layer_pkg
// Description : Shared defaults and FSM encoding for the layer output packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_pkg;

    localparam int c_dw_default         = 16;
    localparam int c_m_default          = 16;
    localparam int c_m2_default         = 64;
    localparam int c_addr_width_default = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } packer_state_t;

endpackage : layer_pkg

`default_nettype wire

// File: rtl/layer_out_packer_pack_slot_reg.sv
// ============================================================================
// Module      : pack_slot_reg
// Description : Staging register and slot counter that gathers M-wide beats
//               into one M2-wide word; optional ReLU under PACKER_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pack_slot_reg
    import layer_pkg::*;
#(
    parameter int M  = c_m_default,
    parameter int M2 = c_m2_default,
    parameter int DW = c_dw_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_capture,
    input  logic [M*DW-1:0]  i_beat,
    output logic [M2*DW-1:0] o_next_word,
    output logic             o_word_last
);

    localparam int SLOTS = M2 / M;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SW-1:0] c_last_slot = SW'(SLOTS - 1);

    logic [M2*DW-1:0] r_stage;
    logic [SW-1:0]    r_slot;
    logic [M*DW-1:0]  w_beat;

`ifdef PACKER_RELU_EN
    for (genvar k = 0; k < M; k++) begin : g_relu
        assign w_beat[k*DW +: DW] = i_beat[k*DW + DW - 1] ? '0 : i_beat[k*DW +: DW];
    end
`else
    assign w_beat = i_beat;
`endif

    // Staged word with the current beat merged in, so the top can register
    // the complete word on the same edge that captures the last slot.
    always_comb begin
        o_next_word = r_stage;
        o_next_word[r_slot*M*DW +: M*DW] = w_beat;
    end

    assign o_word_last = i_capture && (r_slot == c_last_slot);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
            r_slot  <= '0;
        end else if (i_clear) begin
            r_slot <= '0;
        end else if (i_capture) begin
            r_stage <= o_next_word;
            r_slot  <= (r_slot == c_last_slot) ? '0 : r_slot + 1'b1;
        end
    end

endmodule : pack_slot_reg

`default_nettype wire

// File: rtl/layer_out_packer.sv
// ============================================================================
// Module      : layer_out_packer
// Description : Packs adder-tree result beats into BRAM words for the next
//               layer. Define PACKER_RELU_EN to clamp negative values to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_out_packer
    import layer_pkg::*;
#(
    parameter int M           = c_m_default,
    parameter int M2          = c_m2_default,
    parameter int DW          = c_dw_default,
    parameter int ADDR_WIDTH  = c_addr_width_default,
    parameter int FRAME_WORDS = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load,
    input  logic [M*DW-1:0]       out_layer,
    output logic [M2*DW-1:0]      BRAM_wr_data,
    output logic [ADDR_WIDTH-1:0] BRAM_wr_addr,
    output logic                  BRAM_WE,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  drop_err
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FRAME_WORDS - 1);

    packer_state_t         r_state;
    logic [M2*DW-1:0]      r_wr_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_frame_done;
    logic                  r_drop_err;

    logic                  w_capture;
    logic                  w_word_last;
    logic [M2*DW-1:0]      w_next_word;

    // start takes priority: a beat arriving with start is discarded.
    assign w_capture = load && (r_state == FILL) && !start;

    pack_slot_reg #(
        .M  (M),
        .M2 (M2),
        .DW (DW)
    ) u_pack_slot_reg (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (start),
        .i_capture   (w_capture),
        .i_beat      (out_layer),
        .o_next_word (w_next_word),
        .o_word_last (w_word_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_wr_data    <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            if (start) begin
                r_state    <= FILL;
                r_busy     <= 1'b1;
                r_addr     <= '0;
                r_drop_err <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (load) r_drop_err <= 1'b1;
                    end
                    FILL: begin
                        if (w_word_last) begin
                            r_wr_data <= w_next_word;
                            r_we      <= 1'b1;
                        end
                        // The edge that ends a write advances the address.
                        if (r_we) begin
                            r_addr <= r_addr + 1'b1;
                            if (r_addr == c_last_addr) begin
                                r_state      <= DONE;
                                r_busy       <= 1'b0;
                                r_frame_done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (load) r_drop_err <= 1'b1;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign BRAM_wr_data = r_wr_data;
    assign BRAM_wr_addr = r_addr;
    assign BRAM_WE      = r_we;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign drop_err     = r_drop_err;

endmodule : layer_out_packer

`default_nettype wire

// File: doc/layer_out_packer.md
LAYER_OUT_PACKER -- requirements
Module: layer_out_packer

Interface
REQ-001 Parameters SHALL be: M, default 16, filters per load beat; M2, default 64, channels per BRAM word; DW, default 16, bits per value; ADDR_WIDTH, default 10, BRAM address width; FRAME_WORDS, default 784, words per frame.
REQ-002 Ports SHALL be, in this order:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a frame
- load  input  1  beat valid from the layer adder tree
- out_layer  input  M*DW  M results; filter k occupies bits [k*DW +: DW]
- BRAM_wr_data  output  M2*DW  packed word to the next-layer BRAM
- BRAM_wr_addr  output  ADDR_WIDTH  write address
- BRAM_WE  output  1  write strobe
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last word is written
- drop_err  output  1  sticky flag: a load beat was ignored

Function
REQ-003 The FSM SHALL have exactly three states, IDLE, FILL and DONE; busy SHALL be high only in FILL.
REQ-004 State transitions:
- start in any state SHALL go to FILL and clear the slot counter, the address counter and drop_err.
- FILL SHALL go to DONE on the cycle BRAM_WE writes address FRAME_WORDS-1.
- DONE SHALL go to IDLE on the next cycle.
REQ-005 In FILL, each load=1 cycle SHALL capture out_layer into slot s of a staging register at bits [s*M*DW +: M*DW], then increment s modulo M2/M (4 by default).
REQ-006 When the slot-(M2/M - 1) beat is captured:
- the full staged word SHALL be copied into the output register BRAM_wr_data in the same edge;
- BRAM_WE SHALL be high for exactly the following cycle.
This gives a latency of 1 cycle from the last beat to the write.
REQ-007 BRAM_wr_addr SHALL hold the current word address while BRAM_WE is high, and SHALL increment by one on the edge that ends the write.
REQ-008 Back-to-back load beats SHALL be accepted with no stall: staging for word n+1 proceeds while word n is being written.
REQ-009 frame_done SHALL pulse high for one cycle, on the cycle after the final BRAM_WE.
REQ-010 A load in IDLE or DONE SHALL be ignored and SHALL set drop_err. drop_err stays set until start or reset.
REQ-011 If start and load occur in the same cycle, start SHALL win and the beat SHALL be discarded; drop_err stays clear.
REQ-012 If start arrives mid-frame, the partial word SHALL be discarded without a write, and addressing SHALL restart at 0.
REQ-013 Address arithmetic SHALL be unsigned ADDR_WIDTH bits; FRAME_WORDS SHALL be at most 2^ADDR_WIDTH.

Reset
REQ-014 While rst=0, the block SHALL be in:
- state IDLE
- s=0, address 0
- staging register and BRAM_wr_data all zero
- BRAM_WE=0, busy=0, frame_done=0, drop_err=0
REQ-015 Reset asserted mid-frame SHALL abandon the frame with no further write; the first edge after release SHALL behave as IDLE.

Configuration
REQ-016 With the macro PACKER_RELU_EN defined, each DW-bit value SHALL be clamped to 0 when its MSB is 1 (signed negative), before it enters staging.
REQ-017 Without PACKER_RELU_EN, values SHALL pass through unmodified; the port list is identical in both builds.

Structure
REQ-018 The shared package layer_pkg SHALL hold DW, M, M2, ADDR_WIDTH defaults and the FSM state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2).
REQ-019 One sub-module, pack_slot_reg, SHALL implement the staging register, the slot counter and the optional ReLU; the FSM, address counter and flags stay in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic frame: FRAME_WORDS=2; start, then 8 consecutive beats carrying value 16'h0001..16'h0008 in every lane -> BRAM_WE at addr 0 and addr 1, one cycle after beats 4 and 8; word 0 slot 2 = 16'h0003 in every lane; frame_done one cycle after the second write.
- Gapped beats: same as basic frame with 3 idle cycles between beats -> identical data and addresses; BRAM_WE never high for two consecutive cycles.
- Mid-frame restart: 2 beats, then start, then 4 beats of 16'hAAAA -> exactly one write, at addr 0, word all 16'hAAAA.
- Idle drop: load with no prior start -> drop_err=1, BRAM_WE stays 0; a following start -> drop_err=0.
- Start/load collision: start and load in the same cycle -> beat discarded; the next 4 beats form word 0.
- ReLU build: with PACKER_RELU_EN, input lane 16'h8001 -> stored 16'h0000 and 16'h7FFF -> stored 16'h7FFF; without the macro, 16'h8001 is stored unchanged.
